// File: rtl/audio_pause_fader.sv
// Pause fader: ramps the audio gain 64 -> 0 while paused and back to 64 on resume,
// scaling each sample as (audio_in * gain) >> 6 with one clock of latency.
module audio_pause_fader #(
    parameter int STEP_DIV = 48
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_sample,
    input  logic [15:0] audio_in,
    input  logic        pause,
    output logic [15:0] audio_out,
    output logic        muted,
    output logic        fading,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        FADE_OUT = 2'd1,
        MUTED    = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    localparam logic [7:0] STEP_LAST = 8'(STEP_DIV - 1);

    state_t      state, state_n;
    logic [6:0]  gain, gain_n;
    logic [7:0]  cnt, cnt_n;
    logic [22:0] product;

    assign product   = {7'd0, audio_in} * {16'd0, gain};
    assign fsm_state = state;

    // Direction reversals are checked before the step so a reversal always wins.
    // The gain==0 / gain==64 guards cover a reversal that happens before any step.
    always_comb begin
        state_n = state;
        gain_n  = gain;
        cnt_n   = cnt;
        case (state)
            PLAY: begin
                gain_n = 7'd64;
                cnt_n  = 8'd0;
                if (pause) state_n = FADE_OUT;
            end
            MUTED: begin
                gain_n = 7'd0;
                cnt_n  = 8'd0;
                if (!pause) state_n = FADE_IN;
            end
            FADE_OUT: begin
                if (!pause) begin
                    state_n = FADE_IN;
                    cnt_n   = 8'd0;
                end else if (gain == 7'd0) begin
                    state_n = MUTED;
                    cnt_n   = 8'd0;
                end else if (ce_sample) begin
                    if (cnt == STEP_LAST) begin
                        cnt_n  = 8'd0;
                        gain_n = gain - 7'd1;
                        if (gain == 7'd1) state_n = MUTED;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            FADE_IN: begin
                if (pause) begin
                    state_n = FADE_OUT;
                    cnt_n   = 8'd0;
                end else if (gain == 7'd64) begin
                    state_n = PLAY;
                    cnt_n   = 8'd0;
                end else if (ce_sample) begin
                    if (cnt == STEP_LAST) begin
                        cnt_n  = 8'd0;
                        gain_n = gain + 7'd1;
                        if (gain == 7'd63) state_n = PLAY;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_n = PLAY;
                gain_n  = 7'd64;
                cnt_n   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= PLAY;
            gain      <= 7'd64;
            cnt       <= 8'd0;
            audio_out <= 16'h0000;
            muted     <= 1'b0;
            fading    <= 1'b0;
        end else begin
            state  <= state_n;
            gain   <= gain_n;
            cnt    <= cnt_n;
            muted  <= (state_n == MUTED);
            fading <= (state_n == FADE_OUT) || (state_n == FADE_IN);
            // Product uses the gain held before this cycle's step.
            if (ce_sample) audio_out <= 16'(product >> 6);
        end
    end

endmodule

// File: tb/tb_audio_pause_fader.sv
// Directed bench for audio_pause_fader (STEP_DIV=2): expected samples are queued
// at each strobe and compared one clock later; state/flags checked at each step.
module tb_audio_pause_fader;

    localparam int SD = 2;
    localparam logic [1:0] S_PLAY = 2'd0, S_FOUT = 2'd1, S_MUTED = 2'd2, S_FIN = 2'd3;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ce_sample = 1'b0;
    logic [15:0] audio_in = 16'h0000;
    logic        pause = 1'b0;
    logic [15:0] audio_out;
    logic        muted, fading;
    logic [1:0]  fsm_state;

    logic [15:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int g_model = 64;
    int c_model = 0;

    audio_pause_fader #(.STEP_DIV(SD)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_sample(ce_sample),
        .audio_in(audio_in), .pause(pause), .audio_out(audio_out),
        .muted(muted), .fading(fading), .fsm_state(fsm_state)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [1:0] st);
        chk({tag, "_state"}, {30'd0, fsm_state}, {30'd0, st});
        chk({tag, "_muted"}, {31'd0, muted}, {31'd0, st == S_MUTED});
        chk({tag, "_fading"}, {31'd0, fading}, {31'd0, st == S_FOUT || st == S_FIN});
    endtask

    // One strobe: drive sample and pause together, compare output one clock later.
    task automatic strobe(input logic [15:0] din, input logic p, input int g_used);
        logic [15:0] e;
        @(negedge clk_sys);
        ce_sample = 1'b1;
        audio_in  = din;
        pause     = p;
        exp_q.push_back(16'((32'(din) * 32'(g_used)) >> 6));
        @(negedge clk_sys);
        ce_sample = 1'b0;
        e = exp_q.pop_front();
        chk("sample", {16'd0, audio_out}, {16'd0, e});
    endtask

    // n strobes of fading in direction dir with random samples; bench gain model.
    task automatic run(input int n, input int dir);
        for (int i = 0; i < n; i++) begin
            strobe(16'($urandom_range(0, 65535)), pause, g_model);
            c_model++;
            if (c_model == SD) begin
                c_model = 0;
                g_model += dir;
            end
        end
    endtask

    task automatic set_pause(input logic p);
        @(negedge clk_sys);
        pause = p;
        c_model = 0;
        @(negedge clk_sys);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out", {16'd0, audio_out}, 32'd0);
        chk_flags("rst", S_PLAY);
        @(negedge clk_sys);
        reset = 1'b0;

        // Unity gain passthrough
        strobe(16'hFFFF, 1'b0, 64);
        chk_flags("play", S_PLAY);

        // Full fade out with 0x8000 samples
        set_pause(1'b1);
        chk_flags("fout_start", S_FOUT);
        strobe(16'h8000, 1'b1, 64);
        strobe(16'h8000, 1'b1, 64);
        strobe(16'h8000, 1'b1, 63);
        chk("g63_out", {16'd0, audio_out}, 32'h7E00);
        g_model = 63; c_model = 1;
        run(125, -1);
        chk("g_zero_model", 32'(g_model), 32'd0);
        chk_flags("muted", S_MUTED);
        strobe(16'hFFFF, 1'b1, 0);
        chk("muted_out", {16'd0, audio_out}, 32'd0);

        // Full fade in
        set_pause(1'b0);
        chk_flags("fin_start", S_FIN);
        run(128, 1);
        chk_flags("fin_done", S_PLAY);
        strobe(16'h1234, 1'b0, 64);
        chk("play_pass", {16'd0, audio_out}, 32'h1234);

        // Reversal mid-fade: 40 -> 37 -> 39 -> down again
        set_pause(1'b1);
        run(48, -1);
        chk("g40", 32'(g_model), 32'd40);
        chk_flags("at40", S_FOUT);
        run(6, -1);
        set_pause(1'b0);
        chk_flags("rev1", S_FIN);
        run(4, 1);
        chk("g39", 32'(g_model), 32'd39);
        set_pause(1'b1);
        chk_flags("rev2", S_FOUT);
        run(1, -1);

        // Reversal on the same cycle as a step strobe: reversal wins
        strobe(16'hFFFF, 1'b0, 39);
        c_model = 0;
        chk_flags("rev_step", S_FIN);
        strobe(16'h8000, 1'b0, 39);
        chk("rev_hold", {16'd0, audio_out}, 32'd39 * 512);
        c_model = 1;
        run(3, 1);

        // Reset mid-fade at gain 20
        set_pause(1'b1);
        run(2 * (g_model - 20), -1);
        chk("g20", 32'(g_model), 32'd20);
        @(negedge clk_sys);
        pause = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_out", {16'd0, audio_out}, 32'd0);
        chk_flags("rst_mid", S_PLAY);
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        chk_flags("post_rst", S_PLAY);
        strobe(16'hBEEF, 1'b0, 64);
        chk("post_rst_pass", {16'd0, audio_out}, 32'hBEEF);

        // Pause held across reset release
        @(negedge clk_sys);
        pause = 1'b1;
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        chk_flags("rst_pause", S_FOUT);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
